getir_birimi: RTL and testbench

Instruction fetch stage sitting directly upstream of the branch predictor (ongorucu) and the decode stage. Holds the fetch program counter and issues single-outstanding requests to instruction memory. Each returned instruction is presented to the combinational predictor in the same cycle to select the next fetch address. Fetched entries are buffered in a small FIFO toward decode, and the whole path is flushed on a redirect from execute.

---
 rtl/getir_birimi.sv | 170 +++++++++++++++++
 tb/tb_getir_birimi.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/getir_birimi.sv
// Instruction fetch stage: keeps the fetch PC, issues one outstanding memory request at a time,
// consults the predictor on each response and buffers fetched entries toward decode.
module getir_birimi #(
    parameter logic [31:0] RESET_PS  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        bellek_istek_o,
    output logic [31:0] bellek_adres_o,
    input  logic        bellek_hazir_i,
    input  logic        bellek_gecerli_i,
    input  logic [31:0] bellek_veri_i,
    output logic [31:0] ps_o,
    output logic [31:0] buyruk_o,
    input  logic        atlanan_gecerli_i,
    input  logic [31:0] atlanan_ps_i,
    input  logic        duzelt_gecerli_i,
    input  logic [31:0] duzelt_ps_i,
    output logic        coz_gecerli_o,
    output logic [31:0] coz_ps_o,
    output logic [31:0] coz_buyruk_o,
    output logic        coz_tahmin_o,
    input  logic        coz_hazir_i
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ISTEK = 2'd0;
    localparam logic [1:0] BEKLE = 2'd1;
    localparam logic [1:0] DUR   = 2'd2;

    logic [1:0]    durum_q, durum_d;
    logic [31:0]   ps_q, ps_d;
    logic [31:0]   bekleyen_q, bekleyen_d;
    logic          dusur_q, dusur_d;
    logic [AW-1:0] bas_q, bas_d, son_q, son_d;
    logic [CW-1:0] sayac_q, sayac_d;
    logic [31:0]   fifo_ps_q [BUF_DEPTH];
    logic [31:0]   fifo_ps_d [BUF_DEPTH];
    logic [31:0]   fifo_buyruk_q [BUF_DEPTH];
    logic [31:0]   fifo_buyruk_d [BUF_DEPTH];
    logic          fifo_tahmin_q [BUF_DEPTH];
    logic          fifo_tahmin_d [BUF_DEPTH];

    logic istek, kabul, yanit, yanit_al, bos, cek, kredi;

    // Outputs are held at zero while reset is asserted; a response only counts when it is
    // outstanding, not being dropped and not overridden by a redirect.
    always_comb begin
        istek    = (durum_q == ISTEK) && !rst_i;
        kabul    = istek && bellek_hazir_i;
        yanit    = (durum_q == BEKLE) && bellek_gecerli_i && !rst_i;
        yanit_al = yanit && !dusur_q && !duzelt_gecerli_i;
        bos      = (sayac_q == '0);
        cek      = !bos && coz_hazir_i && !duzelt_gecerli_i;

        bellek_istek_o = istek;
        bellek_adres_o = istek ? ps_q : 32'd0;
        ps_o           = yanit_al ? bekleyen_q : 32'd0;
        buyruk_o       = yanit_al ? bellek_veri_i : 32'd0;
        coz_gecerli_o  = !bos;
        coz_ps_o       = bos ? 32'd0 : fifo_ps_q[bas_q];
        coz_buyruk_o   = bos ? 32'd0 : fifo_buyruk_q[bas_q];
        coz_tahmin_o   = bos ? 1'b0 : fifo_tahmin_q[bas_q];
    end

    always_comb begin
        fifo_ps_d     = fifo_ps_q;
        fifo_buyruk_d = fifo_buyruk_q;
        fifo_tahmin_d = fifo_tahmin_q;
        bas_d         = bas_q;
        son_d         = son_q;
        sayac_d       = sayac_q;
        if (duzelt_gecerli_i) begin
            bas_d   = '0;
            son_d   = '0;
            sayac_d = '0;
        end else begin
            if (yanit_al) begin
                fifo_ps_d[son_q]     = bekleyen_q;
                fifo_buyruk_d[son_q] = bellek_veri_i;
                fifo_tahmin_d[son_q] = atlanan_gecerli_i;
                son_d                = son_q + 1'b1;
            end
            if (cek) begin
                bas_d = bas_q + 1'b1;
            end
            sayac_d = sayac_q + CW'(yanit_al) - CW'(cek);
        end
        kredi = (sayac_d < CW'(BUF_DEPTH));
    end

    always_comb begin
        durum_d    = durum_q;
        ps_d       = ps_q;
        bekleyen_d = bekleyen_q;
        dusur_d    = dusur_q;
        case (durum_q)
            ISTEK: begin
                if (kabul) begin
                    durum_d    = BEKLE;
                    bekleyen_d = ps_q;
                    dusur_d    = duzelt_gecerli_i;
                end
                if (duzelt_gecerli_i) begin
                    ps_d = duzelt_ps_i;
                end
            end
            BEKLE: begin
                if (yanit) begin
                    dusur_d = 1'b0;
                    // A dropped or redirected response leaves PC at the redirect target; the flush
                    // emptied the buffer, so credit is always available.
                    if (dusur_q || duzelt_gecerli_i) begin
                        durum_d = ISTEK;
                        if (duzelt_gecerli_i) begin
                            ps_d = duzelt_ps_i;
                        end
                    end else begin
                        ps_d    = atlanan_gecerli_i ? atlanan_ps_i : bekleyen_q + 32'd4;
                        durum_d = kredi ? ISTEK : DUR;
                    end
                end else if (duzelt_gecerli_i) begin
                    dusur_d = 1'b1;
                    ps_d    = duzelt_ps_i;
                end
            end
            DUR: begin
                if (duzelt_gecerli_i) begin
                    ps_d = duzelt_ps_i;
                end
                if (kredi) begin
                    durum_d = ISTEK;
                end
            end
            default: durum_d = ISTEK;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q    <= ISTEK;
            ps_q       <= RESET_PS;
            bekleyen_q <= 32'd0;
            dusur_q    <= 1'b0;
            bas_q      <= '0;
            son_q      <= '0;
            sayac_q    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifo_ps_q[i]     <= 32'd0;
                fifo_buyruk_q[i] <= 32'd0;
                fifo_tahmin_q[i] <= 1'b0;
            end
        end else begin
            durum_q       <= durum_d;
            ps_q          <= ps_d;
            bekleyen_q    <= bekleyen_d;
            dusur_q       <= dusur_d;
            bas_q         <= bas_d;
            son_q         <= son_d;
            sayac_q       <= sayac_d;
            fifo_ps_q     <= fifo_ps_d;
            fifo_buyruk_q <= fifo_buyruk_d;
            fifo_tahmin_q <= fifo_tahmin_d;
        end
    end

endmodule

// File: tb/tb_getir_birimi.sv
// Testbench for getir_birimi: a behavioural instruction memory with adjustable latency, a table-driven
// predictor, and directed sequences for stall, redirect and reset corner cases.
module tb_getir_birimi;

    localparam logic [31:0] RST_PS = 32'h0000_0100;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bellek_istek_o;
    logic [31:0] bellek_adres_o;
    logic        hazir = 1'b1;
    logic        gecerli = 1'b0;
    logic [31:0] veri = 32'd0;
    logic [31:0] ps_o;
    logic [31:0] buyruk_o;
    logic        atl_g = 1'b0;
    logic [31:0] atl_ps = 32'd0;
    logic        duz_g = 1'b0;
    logic [31:0] duz_ps = 32'd0;
    logic        coz_gecerli_o;
    logic [31:0] coz_ps_o;
    logic [31:0] coz_buyruk_o;
    logic        coz_tahmin_o;
    logic        coz_hazir = 1'b1;

    getir_birimi #(.RESET_PS(RST_PS), .BUF_DEPTH(DEPTH)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .bellek_istek_o   (bellek_istek_o),
        .bellek_adres_o   (bellek_adres_o),
        .bellek_hazir_i   (hazir),
        .bellek_gecerli_i (gecerli),
        .bellek_veri_i    (veri),
        .ps_o             (ps_o),
        .buyruk_o         (buyruk_o),
        .atlanan_gecerli_i(atl_g),
        .atlanan_ps_i     (atl_ps),
        .duzelt_gecerli_i (duz_g),
        .duzelt_ps_i      (duz_ps),
        .coz_gecerli_o    (coz_gecerli_o),
        .coz_ps_o         (coz_ps_o),
        .coz_buyruk_o     (coz_buyruk_o),
        .coz_tahmin_o     (coz_tahmin_o),
        .coz_hazir_i      (coz_hazir)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        atla;
        logic [31:0] hedef;
        logic [31:0] exp_adres;
        logic [31:0] exp_ps;
        logic        exp_tahmin;
    } vec_t;

    typedef struct {
        logic [31:0] ps;
        logic [31:0] buyruk;
        logic        tahmin;
    } ent_t;

    vec_t        tbl [12];
    int          tbl_lo = 0;
    int          tbl_hi = 0;
    ent_t        got [$];
    logic [31:0] reqs [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          occ = 0;
    int          max_occ = 0;
    int          lat = 1;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    int          pend_wait = 0;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock cycle: record what the DUT does this cycle, cross the edge, then update memory/predictor.
    task automatic applyStimulus();
        logic        acc;
        logic [31:0] acc_a;
        logic        popped;
        logic        pushed;
        acc    = bellek_istek_o && hazir;
        acc_a  = bellek_adres_o;
        popped = coz_gecerli_o && coz_hazir && !duz_g;
        pushed = (ps_o != 32'd0);
        if (acc) reqs.push_back(acc_a);
        if (popped) got.push_back('{coz_ps_o, coz_buyruk_o, coz_tahmin_o});
        if (rst || duz_g) occ = 0;
        else occ = occ + int'(pushed) - int'(popped);
        if (occ > max_occ) max_occ = occ;
        @(posedge clk);
        #1;
        if (gecerli) begin
            gecerli = 1'b0;
            pend    = 1'b0;
        end
        if (acc) begin
            pend      = 1'b1;
            pend_addr = acc_a;
            pend_wait = lat - 1;
        end else if (pend && pend_wait > 0) begin
            pend_wait--;
        end
        atl_g  = 1'b0;
        atl_ps = 32'd0;
        if (pend && pend_wait == 0) begin
            gecerli = 1'b1;
            veri    = ins(pend_addr);
            for (int i = tbl_lo; i < tbl_hi; i++) begin
                if (tbl[i].exp_adres == pend_addr && tbl[i].atla) begin
                    atl_g  = 1'b1;
                    atl_ps = tbl[i].hedef;
                end
            end
        end else begin
            veri = 32'd0;
        end
        #1;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        hazir     = 1'b1;
        duz_g     = 1'b0;
        coz_hazir = 1'b1;
        lat       = 1;
        pend      = 1'b0;
        applyStimulus();
        applyStimulus();
        got.delete();
        reqs.delete();
        occ = 0;
        rst = 1'b0;
        #1;
    endtask

    task automatic compareTable(input string tag, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            int k;
            k = i - lo;
            checkOutput({tag, " req"}, (k < reqs.size()) ? reqs[k] : 32'hxxxx_xxxx, tbl[i].exp_adres);
            checkOutput({tag, " coz_ps"}, (k < got.size()) ? got[k].ps : 32'hxxxx_xxxx, tbl[i].exp_ps);
            checkOutput({tag, " coz_buyruk"}, (k < got.size()) ? got[k].buyruk : 32'hxxxx_xxxx, ins(tbl[i].exp_ps));
            checkOutput({tag, " coz_tahmin"}, (k < got.size()) ? 32'(got[k].tahmin) : 32'hxxxx_xxxx, 32'(tbl[i].exp_tahmin));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 32'h0,   32'h100, 32'h100, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,   32'h104, 32'h104, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,   32'h108, 32'h108, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,   32'h100, 32'h100, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,   32'h104, 32'h104, 1'b0};
        tbl[5]  = '{1'b1, 32'h200, 32'h108, 32'h108, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,   32'h200, 32'h200, 1'b0};
        tbl[7]  = '{1'b0, 32'h0,   32'h100, 32'h100, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,   32'h104, 32'h104, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,   32'h108, 32'h108, 1'b0};
        tbl[10] = '{1'b0, 32'h0,   32'h10C, 32'h10C, 1'b0};
        tbl[11] = '{1'b0, 32'h0,   32'h110, 32'h110, 1'b0};

        // Reset values, then sequential fetch with no branches
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("rst istek", 32'(bellek_istek_o), 32'd0);
        checkOutput("rst adres", bellek_adres_o, 32'd0);
        checkOutput("rst coz_gecerli", 32'(coz_gecerli_o), 32'd0);
        checkOutput("rst coz_ps", coz_ps_o, 32'd0);
        checkOutput("rst ps_o", ps_o, 32'd0);
        checkOutput("rst buyruk_o", buyruk_o, 32'd0);
        tbl_lo = 0; tbl_hi = 3;
        doReset();
        checkOutput("first istek", 32'(bellek_istek_o), 32'd1);
        checkOutput("first adres", bellek_adres_o, RST_PS);
        applyStimulus();
        checkOutput("resp ps_o", ps_o, 32'h100);
        checkOutput("resp buyruk_o", buyruk_o, ins(32'h100));
        for (int i = 0; i < 8; i++) applyStimulus();
        compareTable("seq", 0, 3);

        // Predicted-taken branch at 0x108
        tbl_lo = 3; tbl_hi = 7;
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus();
        compareTable("taken", 3, 7);

        // Decode stall fills the buffer, then drains in order
        tbl_lo = 7; tbl_hi = 12;
        doReset();
        coz_hazir = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus();
        checkOutput("stall req count", 32'(reqs.size()), 32'd4);
        checkOutput("stall occupancy", 32'(occ), 32'd4);
        checkOutput("stall istek low", 32'(bellek_istek_o), 32'd0);
        checkOutput("stall head ps", coz_ps_o, 32'h100);
        coz_hazir = 1'b1;
        for (int i = 0; i < 12; i++) applyStimulus();
        compareTable("drain", 7, 12);

        // Redirect while waiting on a slow response
        tbl_lo = 0; tbl_hi = 0;
        doReset();
        coz_hazir = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();
        lat = 4;
        applyStimulus();
        checkOutput("pre-redir coz_gecerli", 32'(coz_gecerli_o), 32'd1);
        duz_g  = 1'b1;
        duz_ps = 32'h300;
        applyStimulus();
        duz_g = 1'b0;
        checkOutput("flush coz_gecerli", 32'(coz_gecerli_o), 32'd0);
        applyStimulus();
        applyStimulus();
        checkOutput("drop resp present", 32'(gecerli), 32'd1);
        checkOutput("drop ps_o", ps_o, 32'd0);
        checkOutput("drop buyruk_o", buyruk_o, 32'd0);
        lat = 1;
        coz_hazir = 1'b1;
        applyStimulus();
        checkOutput("redir istek", 32'(bellek_istek_o), 32'd1);
        checkOutput("redir adres", bellek_adres_o, 32'h300);
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("redir got count", 32'(got.size()), 32'd1);
        checkOutput("redir first coz_ps", (got.size() > 0) ? got[0].ps : 32'hxxxx_xxxx, 32'h300);
        checkOutput("redir req 3", (reqs.size() > 3) ? reqs[3] : 32'hxxxx_xxxx, 32'h300);
        checkOutput("drop occupancy", 32'(occ), 32'd0);

        // Redirect, response and pop all in one cycle with two entries buffered
        doReset();
        coz_hazir = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus();
        checkOutput("pre-coll resp", 32'(gecerli), 32'd1);
        duz_g     = 1'b1;
        duz_ps    = 32'h400;
        coz_hazir = 1'b1;
        applyStimulus();
        duz_g = 1'b0;
        checkOutput("coll coz_gecerli", 32'(coz_gecerli_o), 32'd0);
        checkOutput("coll adres", bellek_adres_o, 32'h400);
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("coll got count", 32'(got.size()), 32'd1);
        checkOutput("coll first coz_ps", (got.size() > 0) ? got[0].ps : 32'hxxxx_xxxx, 32'h400);

        // Reset while a request is outstanding; the late response must be ignored
        doReset();
        lat = 6;
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        checkOutput("midrst istek", 32'(bellek_istek_o), 32'd0);
        checkOutput("midrst adres", bellek_adres_o, 32'd0);
        checkOutput("midrst coz_gecerli", 32'(coz_gecerli_o), 32'd0);
        applyStimulus();
        rst   = 1'b0;
        hazir = 1'b0;
        #1;
        checkOutput("postrst istek", 32'(bellek_istek_o), 32'd1);
        checkOutput("postrst adres", bellek_adres_o, RST_PS);
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("late resp present", 32'(gecerli), 32'd1);
        checkOutput("late ps_o", ps_o, 32'd0);
        checkOutput("late buyruk_o", buyruk_o, 32'd0);
        hazir = 1'b1;
        lat   = 1;
        applyStimulus();
        checkOutput("refetch ps_o", ps_o, RST_PS);
        applyStimulus();
        applyStimulus();
        checkOutput("refetch got count", 32'(got.size()), 32'd1);
        checkOutput("refetch coz_ps", (got.size() > 0) ? got[0].ps : 32'hxxxx_xxxx, RST_PS);

        checkOutput("max occupancy", (max_occ <= DEPTH) ? 32'd1 : 32'd0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
